// File: rtl/fp_normalize_round.sv
// Two-stage normalize/round/pack for the single-precision adder; optional FP_NORM_STICKY_FLAGS_EN adds flags_clr/flags_sticky.
// Two cycles from accept to out_valid; each stage advances when empty or drained, so a stalled output backs up into in_ready.

module zero_counter (
  input  logic [27:0] value,
  output logic [4:0]  count
);
  always_comb begin
    count = 5'd28;
    for (int i = 0; i < 28; i++) begin
      if (value[i]) count = 5'(27 - i);
    end
  end
endmodule

module fp_normalize_round #(
  parameter int BIAS      = 127,
  parameter int ROUND_RNE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_sign,
  input  logic [7:0]  in_exp,
  input  logic [27:0] in_mant,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_ovf,
  output logic        out_unf,
  output logic        out_inexact
`ifdef FP_NORM_STICKY_FLAGS_EN
  ,
  input  logic        flags_clr,
  output logic [2:0]  flags_sticky
`endif
);

  localparam logic signed [9:0] EXP_MAX = 10'(2 * BIAS + 1);

  logic               s1_valid;
  logic               s1_sign;
  logic signed [9:0]  s1_exp;
  logic [27:0]        s1_mant;
  logic [4:0]         s1_zc;
  logic [4:0]         zc;
  logic               s2_adv;

  zero_counter u_zc (
    .value (in_mant),
    .count (zc)
  );

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_zc    <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_sign;
        s1_exp  <= {2'b00, in_exp};
        s1_mant <= in_mant;
        s1_zc   <= zc;
      end
    end
  end

  logic [27:0]       norm;
  logic signed [9:0] e_norm;
  logic signed [9:0] e_rnd;
  logic [4:0]        shamt;
  logic              up;
  logic [24:0]       sum;
  logic [22:0]       frac;
  logic [31:0]       nxt_result;
  logic              nxt_ovf;
  logic              nxt_unf;
  logic              nxt_inexact;
  logic              unused_bits;

  always_comb begin
    norm   = s1_mant;
    e_norm = s1_exp;
    shamt  = s1_zc - 5'd1;
    if (s1_zc == 5'd0) begin
      // Carry out of the adder: shift right and fold the lost bit into sticky.
      norm   = {1'b0, s1_mant[27:2], s1_mant[1] | s1_mant[0]};
      e_norm = s1_exp + 10'sd1;
    end else if (s1_zc != 5'd28) begin
      norm   = s1_mant << shamt;
      e_norm = s1_exp - $signed({5'd0, shamt});
    end

    up    = (ROUND_RNE != 0) && norm[2] && (norm[3] || norm[1] || norm[0]);
    sum   = {1'b0, norm[26:3]} + {24'd0, up};
    e_rnd = e_norm + $signed({9'd0, sum[24]});
    frac  = sum[24] ? 23'd0 : sum[22:0];

    nxt_ovf     = 1'b0;
    nxt_unf     = 1'b0;
    nxt_inexact = norm[2] || norm[1] || norm[0];
    nxt_result  = {s1_sign, e_rnd[7:0], frac};
    if (s1_zc == 5'd28) begin
      nxt_result  = {s1_sign, 31'd0};
      nxt_inexact = 1'b0;
    end else if (e_rnd >= EXP_MAX) begin
      nxt_result  = {s1_sign, 8'hFF, 23'd0};
      nxt_ovf     = 1'b1;
      nxt_inexact = 1'b1;
    end else if (e_rnd <= 10'sd0) begin
      nxt_result  = {s1_sign, 31'd0};
      nxt_unf     = 1'b1;
      nxt_inexact = 1'b1;
    end
  end

  assign unused_bits = ^{sum[23], norm[27], e_rnd[9:8]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_result  <= '0;
      out_ovf     <= 1'b0;
      out_unf     <= 1'b0;
      out_inexact <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_result  <= nxt_result;
        out_ovf     <= nxt_ovf;
        out_unf     <= nxt_unf;
        out_inexact <= nxt_inexact;
      end
    end
  end

`ifdef FP_NORM_STICKY_FLAGS_EN
  // A set in the same cycle as a clear survives the clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flags_sticky <= 3'b000;
    end else if (out_valid && out_ready) begin
      flags_sticky <= (flags_clr ? 3'b000 : flags_sticky) | {out_ovf, out_unf, out_inexact};
    end else if (flags_clr) begin
      flags_sticky <= 3'b000;
    end
  end
`endif

endmodule

// File: tb/tb_fp_normalize_round.sv
// Scoreboard bench for fp_normalize_round: RNE and truncating instances share one stimulus stream.
module tb_fp_normalize_round;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready, in_ready_t;
  logic        in_sign = 1'b0;
  logic [7:0]  in_exp = '0;
  logic [27:0] in_mant = '0;
  logic        out_valid, out_valid_t;
  logic        out_ready = 1'b1;
  logic [31:0] out_result, out_result_t;
  logic        out_ovf, out_unf, out_inexact;
  logic        ovf_t, unf_t, inexact_t;
`ifdef FP_NORM_STICKY_FLAGS_EN
  logic        flags_clr = 1'b0;
  logic [2:0]  flags_sticky, flags_sticky_t;
`endif

  always #5 clk = ~clk;

  fp_normalize_round #(.BIAS(127), .ROUND_RNE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_unf(out_unf), .out_inexact(out_inexact)
`ifdef FP_NORM_STICKY_FLAGS_EN
    , .flags_clr(flags_clr), .flags_sticky(flags_sticky)
`endif
  );

  fp_normalize_round #(.BIAS(127), .ROUND_RNE(0)) dut_trunc (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_t),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid_t), .out_ready(out_ready), .out_result(out_result_t),
    .out_ovf(ovf_t), .out_unf(unf_t), .out_inexact(inexact_t)
`ifdef FP_NORM_STICKY_FLAGS_EN
    , .flags_clr(flags_clr), .flags_sticky(flags_sticky_t)
`endif
  );

  typedef struct packed {
    logic [31:0] res;
    logic [31:0] trunc;
    logic [2:0]  flags;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_result = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h required %h at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("hold_stable", out_result, prev_result);
      check("trunc_valid_lockstep", {31'd0, out_valid_t}, {31'd0, out_valid});
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_output", {31'd0, out_valid}, 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("result", out_result, e.res);
          check("trunc_result", out_result_t, e.trunc);
          check("flags", {29'd0, out_ovf, out_unf, out_inexact}, {29'd0, e.flags});
        end
      end
      prev_stall  = out_valid && !out_ready;
      prev_result = out_result;
    end
  end

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic s, input logic [7:0] e, input logic [27:0] m,
                      input logic [31:0] r, input logic [31:0] rt, input logic [2:0] fl,
                      input bit want);
    bit ok = 1'b0;
    int n = 0;
    in_valid = 1'b1;
    in_sign  = s;
    in_exp   = e;
    in_mant  = m;
    while (!ok && n < 200) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      n++;
    end
    if (!ok) check("accept_timeout", 32'd0, 32'd1);
    else if (want) sb.push_back('{res: r, trunc: rt, flags: fl});
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
  endtask

  initial begin
    #1;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_result", out_result, 32'd0);
    check("reset_flags", {29'd0, out_ovf, out_unf, out_inexact}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // Plain value with latency probe.
    send(1'b0, 8'h80, 28'h4000000, 32'h40000000, 32'h40000000, 3'b000, 1'b1);
    idle();
    @(negedge clk);
    check("latency_not_yet", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    check("latency_two", {31'd0, out_valid}, 32'd1);
    @(posedge clk); #1;

    // Back-to-back directed vectors.
    send(1'b0, 8'h7F, 28'h8000000, 32'h40000000, 32'h40000000, 3'b000, 1'b1);
    send(1'b0, 8'h85, 28'h0800000, 32'h41000000, 32'h41000000, 3'b000, 1'b1);
    send(1'b0, 8'h7F, 28'h4000004, 32'h3F800000, 32'h3F800000, 3'b001, 1'b1);
    send(1'b0, 8'h7F, 28'h400000C, 32'h3F800002, 32'h3F800001, 3'b001, 1'b1);
    send(1'b1, 8'h40, 28'h0000000, 32'h80000000, 32'h80000000, 3'b000, 1'b1);
    send(1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 32'h7F800000, 3'b101, 1'b1);
    send(1'b0, 8'h02, 28'h0100000, 32'h00000000, 32'h00000000, 3'b011, 1'b1);
    send(1'b0, 8'h7F, 28'h7FFFFFC, 32'h40000000, 32'h3FFFFFFF, 3'b001, 1'b1);
    send(1'b0, 8'h7F, 28'h8000003, 32'h40000000, 32'h40000000, 3'b001, 1'b1);
    idle();

    // Backpressure: output stalled for four cycles while five beats stream in.
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 5; k++)
          send(1'b0, 8'h80, 28'h4000000 + 28'(k * 8), 32'h40000000 + 32'(k),
               32'h40000000 + 32'(k), 3'b000, 1'b1);
        idle();
      end
      begin
        repeat (3) @(negedge clk);
        check("in_ready_drops", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    #1;

    // Reset with both stages full: in-flight beats must vanish.
    out_ready = 1'b0;
    send(1'b0, 8'h90, 28'h4000000, 32'h0, 32'h0, 3'b000, 1'b0);
    send(1'b0, 8'h91, 28'h4000000, 32'h0, 32'h0, 3'b000, 1'b0);
    idle();
    check("full_before_reset", {30'd0, out_valid, in_ready}, 32'd2);
    #2 rst = 1'b1;
    #1;
    check("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check("async_reset_result", out_result, 32'd0);
    @(negedge clk);
    #3 rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("no_stale_after_reset", {31'd0, out_valid}, 32'd0);
    end
    @(posedge clk); #1;
    send(1'b1, 8'h81, 28'h6000000, 32'hC0C00000, 32'hC0C00000, 3'b000, 1'b1);
    idle();

`ifdef FP_NORM_STICKY_FLAGS_EN
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    #1 flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    check("sticky_cleared", {29'd0, flags_sticky}, 32'd0);
    send(1'b0, 8'hFE, 28'h8000000, 32'h7F800000, 32'h7F800000, 3'b101, 1'b1);
    idle();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check("sticky_ovf", {29'd0, flags_sticky}, 32'd5);
    flags_clr = 1'b1;
    @(posedge clk); #1 flags_clr = 1'b0;
    check("sticky_clr", {29'd0, flags_sticky}, 32'd0);
`endif

    for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk);
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fp_normalize_round.md
Name: fp_normalize_round

Overview:
- Two-stage pipelined normalize-and-round stage for the single-precision FP adder.
- Sits directly downstream of the mantissa add/subtract stage.
- Instantiates the team's 28-bit `zero_counter` (leading-zero count: 28 when all zero, 0 when bit 27 set).
- Uses that count to shift the raw mantissa, adjust the exponent, round, and pack an IEEE-754 single result.
- Valid/ready handshake on both sides; one result per cycle sustained.

Parameters:
- BIAS, 127, exponent bias used for overflow/underflow limits.
- ROUND_RNE, 1, 1 = round-to-nearest-even; 0 = truncate (G/R/S discarded).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept a beat.
- in_sign  in  1  result sign.
- in_exp  in  8  biased exponent, pre-normalization.
- in_mant  in  28  bit 27 carry, bit 26 hidden, bits 25:3 fraction, bit 2 guard, bit 1 round, bit 0 sticky.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts.
- out_result  out  32  packed {sign, exp[7:0], frac[22:0]}.
- out_ovf  out  1  overflow flag, qualified by out_valid.
- out_unf  out  1  underflow flag, qualified by out_valid.
- out_inexact  out  1  G, R or S nonzero after shift, qualified by out_valid.

Behaviour:
- Reset (async, rst=1): all stage valids 0; out_valid=0; out_result=0; all flags 0. in_ready=1 from the first cycle after rst deasserts. A beat in flight is discarded, with no partial output.
- Stage 1 (S1): on accept (in_valid & in_ready), register sign, exp (zero-extended to a signed 10-bit value), mant, and Zcount from `zero_counter`.
- Stage 2 (S2): shift, exponent adjust, round, pack. Results are registered onto the out_* ports.
- Latency: 2 cycles from accept to out_valid when not stalled.
- Handshake:
  - A stage advances when it is empty or its downstream consumes.
  - in_ready = !s1_valid | (s1 advances into S2 this cycle).
  - out_* hold stable while out_valid & !out_ready.
  - No bubbles at full throughput; order preserved; no beat dropped or duplicated.
- Normalization (E = exponent, signed 10-bit):
  - Zcount==28 (mant zero): result {sign, 31'b0}; all flags 0.
  - Zcount==0 (carry): shift right 1; new bit 0 = old bit1|bit0; E=E+1.
  - Zcount==1: no shift.
  - Zcount 2..27: shift left by Zcount-1; E=E-(Zcount-1).
- Rounding (ROUND_RNE=1):
  - up = bit2 & (bit3 | bit1 | bit0).
  - Increment bits 26:3.
  - Carry out of bit 26: fraction becomes 0, E=E+1.
- Range checks after rounding:
  - E>=255: out_result={sign,8'hFF,23'b0}, out_ovf=1.
  - E<=0: out_result={sign,31'b0}, out_unf=1. Flush-to-zero; no denormals produced.
- out_inexact = bit2|bit1|bit0 after the shift; also forced to 1 on overflow or underflow.
- Simultaneous output consume and input accept in the same cycle: both occur; the pipeline stays full.

Optional Feature:
- Macro: FP_NORM_STICKY_FLAGS_EN.
- When defined:
  - Adds input flags_clr (1) and output flags_sticky (3) = {ovf, unf, inexact}.
  - Bits set on every output handshake (out_valid & out_ready) where the flag is 1.
  - Cleared to 0 by reset or flags_clr.
  - flags_clr and a set in the same cycle: the set wins.
- When undefined: both ports and the register are absent; all other behaviour is identical.

Test Plan:
1. sign=0, exp=0x80, mant=0x4000000 -> out_result=0x40000000 exactly 2 cycles after accept; no flags.
2. exp=0x7F, mant=0x8000000 (carry) -> 0x40000000. Also exp=0x85, mant=0x0800000 (Zcount=4) -> 0x41000000.
3. Rounding, exp=0x7F:
   - mant=0x4000004 (tie, LSB 0) -> 0x3F800000, inexact=1.
   - mant=0x400000C (tie, LSB 1) -> 0x3F800002.
   - ROUND_RNE=0 with mant=0x400000C -> 0x3F800001.
4. Special cases:
   - sign=1, mant=0 -> 0x80000000.
   - exp=0xFE, mant=0x8000000 -> 0x7F800000, ovf=1.
   - exp=0x02, mant=0x0100000 -> 0x00000000, unf=1.
5. Backpressure: stream 5 beats with out_ready=0 for 4 cycles -> in_ready drops after 2 beats held; all 5 results emerge in order, and out_result is stable while stalled.
6. Reset mid-operation: assert rst with both stages full -> out_valid=0 immediately (async); no stale result after release. Under FP_NORM_STICKY_FLAGS_EN, ovf then flags_clr -> flags_sticky=3'b000.
